// File: rtl/irq_mc_pkg.sv
// Shared definitions for the multi-channel interrupt controller: register map,
// FSM encoding and control-bit positions.
package irq_mc_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_PEND   = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam logic [2:0] REG_VBASE  = 3'd5;
    localparam logic [2:0] REG_EOI    = 3'd6;
    localparam logic [2:0] REG_CUR    = 3'd7;

    localparam int CTRL_EN = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request is set and
// the index of the lowest set bit.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [4:0]   id_o
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller_mc.sv
// Multi-channel interrupt controller: synchronises sources, tracks pending state,
// arbitrates by lowest index and runs the request/service handshake with the core.
module irq_controller_mc
    import irq_mc_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_RESET   = 32'h0000_0010,
    parameter int          VEC_STRIDE  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               reg_sel_i,
    input  logic [2:0]         reg_addr_i,
    input  logic               reg_we_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               irq_cpu_o,
    output logic [31:0]        irq_vector_o,
    input  logic               irq_ack_cpu_i,
    output logic [4:0]         irq_id_o
);

    localparam int STRIDE_SHIFT = $clog2(VEC_STRIDE);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] syncPrev_q;
    logic [NUM_IRQ-1:0] synced;
    logic [NUM_IRQ-1:0] rise;

    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic               en_q;
    logic [31:0]        vbase_q;

    irq_state_e         state_q;
    irq_state_e         state_d;
    logic [4:0]         id_q;
    logic [31:0]        vector_q;
    logic               inService;

    logic               wrEn;
    logic               wrMask;
    logic               wrMode;
    logic               wrPend;
    logic               wrCtrl;
    logic               wrVbase;
    logic               eoiWr;
    logic [NUM_IRQ-1:0] wdataIrq;

    logic [NUM_IRQ-1:0] eligible;
    logic [31:0]        eligible32;
    logic               latchedEligible;
    logic               winValid;
    logic [4:0]         winId;
    logic [NUM_IRQ-1:0] idOneHot;
    logic [NUM_IRQ-1:0] ackClr;
    logic [NUM_IRQ-1:0] w1c;
    logic [31:0]        vecCalc;

    assign wrEn     = reg_sel_i & reg_we_i & ~stall_i;
    assign wrMask   = wrEn && (reg_addr_i == REG_MASK);
    assign wrMode   = wrEn && (reg_addr_i == REG_MODE);
    assign wrPend   = wrEn && (reg_addr_i == REG_PEND);
    assign wrCtrl   = wrEn && (reg_addr_i == REG_CTRL);
    assign wrVbase  = wrEn && (reg_addr_i == REG_VBASE);
    assign eoiWr    = wrEn && (reg_addr_i == REG_EOI);
    assign wdataIrq = reg_wdata_i[NUM_IRQ-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            syncPrev_q <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            syncPrev_q <= synced;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~syncPrev_q;

    assign idOneHot = NUM_IRQ'(32'd1 << id_q);
    assign ackClr   = (state_q == REQ && irq_ack_cpu_i && !stall_i) ? idOneHot : '0;
    assign w1c      = wrPend ? wdataIrq : '0;

    // A fresh edge wins over a W1C or ack clear landing in the same cycle.
    assign pend_d = (mode_q & ((pend_q & ~w1c & ~ackClr) | rise)) | (~mode_q & synced);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mask_q  <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            en_q    <= 1'b0;
            vbase_q <= VEC_RESET;
        end else begin
            pend_q <= pend_d;
            if (wrMask) begin
                mask_q <= wdataIrq;
            end
            if (wrMode) begin
                mode_q <= wdataIrq;
            end
            if (wrCtrl) begin
                en_q <= reg_wdata_i[CTRL_EN];
            end
            if (wrVbase) begin
                vbase_q <= reg_wdata_i;
            end
        end
    end

    assign eligible        = pend_q & mask_q & {NUM_IRQ{en_q}};
    assign eligible32      = 32'(eligible);
    assign latchedEligible = eligible32[id_q];

    irq_prio_enc #(
        .N(NUM_IRQ)
    ) u_prio_enc (
        .req_i  (eligible),
        .valid_o(winValid),
        .id_o   (winId)
    );

    assign vecCalc = vbase_q + (32'(winId) << STRIDE_SHIFT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stall_i) begin
            unique case (state_q)
                IDLE: if (winValid) state_d = REQ;
                REQ: begin
                    if (irq_ack_cpu_i) begin
                        state_d = SERV;
                    end else if (!latchedEligible) begin
                        state_d = IDLE;
                    end
                end
                SERV: if (eoiWr) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        irq_cpu_o = (state_q == REQ);
        inService = (state_q == SERV);
    end

    // Id and vector are frozen at the IDLE->REQ edge so a later winner cannot preempt.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_q     <= '0;
            vector_q <= VEC_RESET;
        end else if (state_q == IDLE && state_d == REQ) begin
            id_q     <= winId;
            vector_q <= vecCalc;
        end
    end

    assign irq_id_o     = id_q;
    assign irq_vector_o = vector_q;

    always_comb begin
        reg_rdata_o = '0;
        case (reg_addr_i)
            REG_STATUS: reg_rdata_o = 32'(synced);
            REG_MASK:   reg_rdata_o = 32'(mask_q);
            REG_MODE:   reg_rdata_o = 32'(mode_q);
            REG_PEND:   reg_rdata_o = 32'(pend_q);
            REG_CTRL:   reg_rdata_o[CTRL_EN] = en_q;
            REG_VBASE:  reg_rdata_o = vbase_q;
            REG_CUR:    reg_rdata_o = {inService, 26'b0, id_q};
            default:    reg_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller_mc.sv
// Self-checking bench for irq_controller_mc: register table, scoreboarded
// request monitor and hand-written multi-cycle sequences.
module tb_irq_controller_mc;
    import irq_mc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic [7:0]  irq_src_i;
    logic        reg_sel_i;
    logic [2:0]  reg_addr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        irq_cpu_o;
    logic [31:0] irq_vector_o;
    logic        irq_ack_cpu_i;
    logic [4:0]  irq_id_o;

    typedef struct packed {
        logic [2:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } regVec_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] vector;
    } reqExp_t;

    reqExp_t scoreQ[$];
    regVec_t vecs[8];
    int      passCount  = 0;
    int      checkCount = 0;
    logic    cpuPrev    = 1'b0;
    logic [31:0] rd;

    irq_controller_mc #(
        .NUM_IRQ    (8),
        .SYNC_STAGES(2),
        .VEC_RESET  (32'h0000_0010),
        .VEC_STRIDE (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stall_i      (stall_i),
        .irq_src_i    (irq_src_i),
        .reg_sel_i    (reg_sel_i),
        .reg_addr_i   (reg_addr_i),
        .reg_we_i     (reg_we_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rdata_o  (reg_rdata_o),
        .irq_cpu_o    (irq_cpu_o),
        .irq_vector_o (irq_vector_o),
        .irq_ack_cpu_i(irq_ack_cpu_i),
        .irq_id_o     (irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    // Every rising request is matched against the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rst_ni && irq_cpu_o && !cpuPrev) begin
            if (scoreQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected request: actual id=%0d required=none", irq_id_o);
            end else begin
                reqExp_t e;
                e = scoreQ.pop_front();
                checkOutput("request id", 32'(irq_id_o), 32'(e.id));
                checkOutput("request vector", irq_vector_o, e.vector);
            end
        end
        cpuPrev = irq_cpu_o;
    end

    task automatic expectReq(input logic [4:0] id, input logic [31:0] vector);
        reqExp_t e;
        e.id     = id;
        e.vector = vector;
        scoreQ.push_back(e);
    endtask

    task automatic waitScoreboard(input int maxCycles);
        int n = 0;
        while (scoreQ.size() != 0 && n < maxCycles) begin
            @(posedge clk_i);
            n++;
        end
        if (scoreQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL request timeout: actual=%0d outstanding required=0", scoreQ.size());
            scoreQ.delete();
        end
    endtask

    task automatic regWrite(input logic [2:0] addr, input logic [31:0] data);
        @(posedge clk_i);
        #1;
        reg_sel_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        @(posedge clk_i);
        #1;
        reg_sel_i = 1'b0;
        reg_we_i  = 1'b0;
    endtask

    task automatic regRead(input logic [2:0] addr, output logic [31:0] data);
        @(posedge clk_i);
        #2;
        reg_addr_i = addr;
        #1;
        data = reg_rdata_o;
    endtask

    task automatic pulseAck();
        @(posedge clk_i);
        #1;
        irq_ack_cpu_i = 1'b1;
        @(posedge clk_i);
        #1;
        irq_ack_cpu_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk_i);
    endtask

    // Apply one register-table record: optional write, then read-back compare.
    task automatic applyStimulus(input regVec_t v, input int idx);
        logic [31:0] r;
        if (v.we) begin
            regWrite(v.addr, v.wdata);
        end
        regRead(v.addr, r);
        checkOutput($sformatf("regvec%0d", idx), r, v.exp);
    endtask

    initial begin
        vecs[0] = '{REG_MASK,   1'b1, 32'hFFFF_FF5A, 32'h0000_005A};
        vecs[1] = '{REG_MODE,   1'b1, 32'h1234_56A5, 32'h0000_00A5};
        vecs[2] = '{REG_VBASE,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{REG_CTRL,   1'b1, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[4] = '{REG_CTRL,   1'b1, 32'h0000_0001, 32'h0000_0001};
        vecs[5] = '{REG_STATUS, 1'b0, 32'h0,         32'h0000_0000};
        vecs[6] = '{REG_EOI,    1'b0, 32'h0,         32'h0000_0000};
        vecs[7] = '{REG_CUR,    1'b0, 32'h0,         32'h0000_0000};

        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        irq_src_i     = 8'hFF;
        reg_sel_i     = 1'b0;
        reg_addr_i    = 3'd0;
        reg_we_i      = 1'b0;
        reg_wdata_i   = 32'h0;
        irq_ack_cpu_i = 1'b0;

        // Reset with all sources asserted
        idle(3);
        #1;
        checkOutput("reset irq_cpu", 32'(irq_cpu_o), 32'h0);
        checkOutput("reset id", 32'(irq_id_o), 32'h0);
        checkOutput("reset vector", irq_vector_o, 32'h10);
        regRead(REG_VBASE, rd);
        checkOutput("reset vbase", rd, 32'h10);
        regRead(REG_PEND, rd);
        checkOutput("reset pend", rd, 32'h0);
        irq_src_i = 8'h00;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(4);

        // Register table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end
        regWrite(REG_CTRL, 32'h0);
        regWrite(REG_MASK, 32'h0);
        regWrite(REG_MODE, 32'h0);
        regWrite(REG_VBASE, 32'h10);

        // Edge channel latency, ack and EOI
        regWrite(REG_MODE, 32'h04);
        regWrite(REG_MASK, 32'h04);
        regWrite(REG_CTRL, 32'h01);
        expectReq(5'd2, 32'h18);
        @(posedge clk_i);
        #1 irq_src_i = 8'h04;
        @(posedge clk_i);
        #1 irq_src_i = 8'h00;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 checkOutput("edge latency early", 32'(irq_cpu_o), 32'h0);
        @(posedge clk_i);
        #1 checkOutput("edge latency", 32'(irq_cpu_o), 32'h1);
        waitScoreboard(4);
        regRead(REG_PEND, rd);
        checkOutput("edge pend before ack", rd, 32'h04);
        pulseAck();
        checkOutput("irq_cpu after ack", 32'(irq_cpu_o), 32'h0);
        regRead(REG_PEND, rd);
        checkOutput("edge pend after ack", rd, 32'h0);
        regRead(REG_CUR, rd);
        checkOutput("cur in service", rd, 32'h8000_0002);
        regWrite(REG_EOI, 32'h0);
        regRead(REG_CUR, rd);
        checkOutput("cur after eoi", rd, 32'h0000_0002);

        // Level priority and re-request while source stays high
        regWrite(REG_MODE, 32'h00);
        regWrite(REG_MASK, 32'hFF);
        expectReq(5'd3, 32'h1C);
        irq_src_i = 8'h28;
        waitScoreboard(10);
        pulseAck();
        expectReq(5'd3, 32'h1C);
        regWrite(REG_EOI, 32'h0);
        waitScoreboard(4);
        pulseAck();
        irq_src_i = 8'h20;
        idle(5);
        expectReq(5'd5, 32'h24);
        regWrite(REG_EOI, 32'h0);
        waitScoreboard(4);
        pulseAck();
        irq_src_i = 8'h00;
        idle(5);
        regWrite(REG_EOI, 32'h0);
        idle(3);
        #1 checkOutput("level idle", 32'(irq_cpu_o), 32'h0);

        // Withdrawn level request
        expectReq(5'd1, 32'h14);
        irq_src_i = 8'h02;
        waitScoreboard(10);
        #1 irq_src_i = 8'h00;
        begin
            int n = 0;
            while (irq_cpu_o && n < 6) begin
                @(posedge clk_i);
                #1 n++;
            end
        end
        checkOutput("withdraw cpu low", 32'(irq_cpu_o), 32'h0);
        regRead(REG_CUR, rd);
        checkOutput("withdraw cur idle", rd, 32'h0000_0001);
        pulseAck();
        regRead(REG_CUR, rd);
        checkOutput("ack outside req ignored", rd, 32'h0000_0001);
        checkOutput("withdraw vector", irq_vector_o, 32'h14);

        // Edge set beats W1C in the same cycle
        regWrite(REG_MASK, 32'h00);
        regWrite(REG_MODE, 32'h01);
        @(posedge clk_i);
        #1 irq_src_i = 8'h01;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reg_sel_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = REG_PEND;
        reg_wdata_i = 32'h1;
        @(posedge clk_i);
        #1;
        reg_sel_i = 1'b0;
        reg_we_i  = 1'b0;
        regRead(REG_PEND, rd);
        checkOutput("set beats w1c", rd, 32'h01);
        regWrite(REG_PEND, 32'h1);
        regRead(REG_PEND, rd);
        checkOutput("w1c clears", rd, 32'h00);
        irq_src_i = 8'h00;

        // Vector arithmetic wraps at 32 bits
        regWrite(REG_MODE, 32'h00);
        regWrite(REG_VBASE, 32'hFFFF_FFFC);
        regWrite(REG_MASK, 32'h02);
        expectReq(5'd1, 32'h0000_0000);
        irq_src_i = 8'h02;
        waitScoreboard(10);
        #1 checkOutput("wrap vector", irq_vector_o, 32'h0);
        pulseAck();
        irq_src_i = 8'h00;
        idle(5);
        regWrite(REG_EOI, 32'h0);
        regWrite(REG_VBASE, 32'h10);

        // Stall freezes FSM and drops writes
        regWrite(REG_MASK, 32'h10);
        expectReq(5'd4, 32'h20);
        irq_src_i = 8'h10;
        waitScoreboard(10);
        #1 stall_i = 1'b1;
        pulseAck();
        regWrite(REG_MASK, 32'h00);
        regRead(REG_MASK, rd);
        checkOutput("stall mask kept", rd, 32'h10);
        checkOutput("stall still req", 32'(irq_cpu_o), 32'h1);
        regRead(REG_CUR, rd);
        checkOutput("stall cur", rd, 32'h0000_0004);
        #1 stall_i = 1'b0;
        pulseAck();
        regRead(REG_CUR, rd);
        checkOutput("ack after stall", rd, 32'h8000_0004);
        checkOutput("cpu low after stall ack", 32'(irq_cpu_o), 32'h0);
        irq_src_i = 8'h00;
        idle(5);
        regWrite(REG_EOI, 32'h0);

        // Reset during a live request
        regWrite(REG_MASK, 32'h40);
        expectReq(5'd6, 32'h28);
        irq_src_i = 8'h40;
        waitScoreboard(10);
        #1 rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("mid reset irq_cpu", 32'(irq_cpu_o), 32'h0);
        checkOutput("mid reset vector", irq_vector_o, 32'h10);
        regRead(REG_MASK, rd);
        checkOutput("mid reset mask", rd, 32'h0);
        irq_src_i = 8'h00;
        #1 rst_ni = 1'b1;
        idle(5);
        #1 checkOutput("post reset idle", 32'(irq_cpu_o), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
